mul_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_div_core.sv | 62 ++++++
 rtl/mul_div_unit.sv | 206 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: operation encodings, M-extension func7 and FSM state type shared by
// the multiply/divide unit and its bench.
package mdu_pkg;

    localparam logic [6:0] F7_MEXT   = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core: unsigned restoring divider, one quotient bit per step; the
// dividend register doubles as the quotient shift register.
module mdu_div_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    input  logic [CNT_W-1:0] count,
    output logic [XLEN-1:0]  quotient,
    output logic [XLEN-1:0]  remainder,
    output logic             last
);
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dvsr_q};
        if (load) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvsr_d = divisor;
        end else if (step) begin
            // A clear top bit means no borrow: the divisor fits, keep the difference.
            if (!trial[XLEN]) begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign last      = (count == '0);

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit with sign fix-up and FSM.
// Define MDU_FAST_MUL_EN to resolve multiplies in the accept cycle with a combinational product.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic            illegal,
    output logic [XLEN-1:0] result
);
    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [XLEN-1:0]  ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X  = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic                ill_q, ill_d;
    logic [XLEN-1:0]     mcand_q, mcand_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                accept, legal, in_neg_a, in_neg_b;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     mag_a, mag_b, special_res;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_res;
    logic                div_load, div_step, div_last;
    logic [XLEN-1:0]     div_quo, div_rem;

`ifdef MDU_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]          fast_res;

    // Sign- or zero-extended operands; the low 2*XLEN bits of the product are exact.
    always_comb begin
        fast_a    = $signed({{XLEN{rs1_signed(func3) && rs1[XLEN-1]}}, rs1});
        fast_b    = $signed({{XLEN{rs2_signed(func3) && rs2[XLEN-1]}}, rs2});
        fast_prod = fast_a * fast_b;
        fast_res  = (func3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif

    // Accept-cycle decode: magnitudes, sign flags and single-cycle outcomes.
    always_comb begin
        accept      = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
        legal       = (func7 == F7_MEXT);
        in_neg_a    = rs1_signed(func3) && rs1[XLEN-1];
        in_neg_b    = rs2_signed(func3) && rs2[XLEN-1];
        mag_a       = in_neg_a ? (~rs1 + ONE_X) : rs1;
        mag_b       = in_neg_b ? (~rs2 + ONE_X) : rs2;
        div_zero    = is_div(func3) && (rs2 == '0);
        div_ovf     = is_div(func3) && !func3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
        special     = 1'b0;
        special_res = '0;
        if (!legal) begin
            special = 1'b1;
        end else if (div_zero) begin
            special     = 1'b1;
            special_res = func3[1] ? rs1 : '1;
        end else if (div_ovf) begin
            special     = 1'b1;
            special_res = func3[1] ? '0 : rs1;
        end
`ifdef MDU_FAST_MUL_EN
        else if (!is_div(func3)) begin
            special     = 1'b1;
            special_res = fast_res;
        end
`endif
    end

    // Shift-add step and final sign fix-up.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + ONE_2X) : acc_q;
        quo_fix  = (neg_a_q ^ neg_b_q) ? (~div_quo + ONE_X) : div_quo;
        rem_fix  = neg_a_q ? (~div_rem + ONE_X) : div_rem;
        unique case (op_q)
            F3_MUL:                        fix_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fix_res = quo_fix;
            default:                       fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        ill_d    = ill_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        div_load = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    op_d    = func3;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    ill_d   = !legal;
                    if (special) begin
                        state_d  = S_DONE;
                        result_d = special_res;
                    end else begin
                        state_d  = S_CALC;
                        cnt_d    = CNT_INIT;
                        acc_d    = {{XLEN{1'b0}}, mag_b};
                        mcand_d  = mag_a;
                        div_load = is_div(func3);
                    end
                end
            end
            S_CALC: begin
                if (is_div(op_q)) begin
                    div_step = 1'b1;
                end else begin
                    acc_d = mul_next;
                end
                if (div_last) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over everything, including a result about to be written.
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= F3_MUL;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            ill_q    <= 1'b0;
            mcand_q  <= '0;
            result_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            ill_q    <= ill_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    mdu_div_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (div_load),
        .step      (div_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .count     (cnt_q),
        .quotient  (div_quo),
        .remainder (div_rem),
        .last      (div_last)
    );

    assign busy    = (state_q == S_CALC) || (state_q == S_FIX);
    assign done    = (state_q == S_DONE);
    assign illegal = (state_q == S_DONE) && ill_q;
    assign result  = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized stimulus for mul_div_unit; a monitor
// checks every done pulse against expectations queued by the driver.
`timescale 1ns/1ps
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int XLEN     = 32;
    localparam int LAT_ITER = XLEN + 2;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          due;
        logic [2:0]  f3;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush;
    logic [6:0]  func7;
    logic [2:0]  func3;
    logic [31:0] rs1, rs2;
    logic        busy, done, illegal;
    logic [31:0] result;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txn = 0;
    logic [31:0] last_res = '0;
    exp_t        sb_q[$];

    mul_div_unit #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .flush   (flush),
        .func7   (func7),
        .func3   (func3),
        .rs1     (rs1),
        .rs2     (rs2),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .result  (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RV32M semantics from plain 64-bit arithmetic.
    function automatic exp_t ref_op(input logic [6:0] f7, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, ua, ub, q;
        logic [63:0] p;
        logic        ovf;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        ua    = longint'({32'b0, a});
        ub    = longint'({32'b0, b});
        ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        e.res = '0;
        e.ill = 1'b0;
        e.due = 0;
        e.f3  = f3;
        if (f7 != 7'b0000001) begin
            e.ill = 1'b1;
            return e;
        end
        case (f3)
            3'd0: begin p = sa * sb; e.res = p[31:0];  end
            3'd1: begin p = sa * sb; e.res = p[63:32]; end
            3'd2: begin p = sa * ub; e.res = p[63:32]; end
            3'd3: begin p = ua * ub; e.res = p[63:32]; end
            3'd4: begin
                if (b == 0)   e.res = 32'hFFFF_FFFF;
                else if (ovf) e.res = a;
                else begin q = sa / sb; e.res = q[31:0]; end
            end
            3'd5: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0)   e.res = a;
                else if (ovf) e.res = 32'h0;
                else begin q = sa % sb; e.res = q[31:0]; end
            end
            default: e.res = (b == 0) ? a : a % b;
        endcase
        return e;
    endfunction

    function automatic int ref_lat(input logic [6:0] f7, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b);
        if (f7 != 7'b0000001) return 1;
        if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
`ifdef MDU_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return LAT_ITER;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Called at a negedge; leaves start asserted so a following call can chain
    // into the DONE cycle. With push clear the operation is expected to be aborted.
    task automatic issue(input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit use_exp, input logic [31:0] exp_res,
                         input bit push, output int t0);
        exp_t e;
        int   lat;
        int   guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_wait: busy still %0b after %0d cycles, required 0", busy, guard);
        end
        e   = ref_op(f7, f3, a, b);
        lat = ref_lat(f7, f3, a, b);
        if (use_exp) e.res = exp_res;
        e.due = cyc + lat;
        t0    = cyc;
        func7 = f7;
        func3 = f3;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        if (push) begin
            sb_q.push_back(e);
            last_res = e.res;
        end
        @(negedge clk);
        if (push) chk("busy_after_accept", {31'b0, busy}, 32'(lat > 1));
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        start = 1'b0;
        while ((sb_q.size() != 0 || busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with result %h, required no done",
                         cyc, result);
            end else begin
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
                chk("done_cycle", cyc, e.due);
                n_txn++;
                $display("txn %0d f3=%0d result=%h illegal=%0b cycle=%0d",
                         n_txn, e.f3, result, illegal, cyc);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d results outstanding", sb_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int          t0;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a, b;

        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        func7 = '0;
        func3 = '0;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",    {31'b0, busy},    32'h0);
        chk("reset_done",    {31'b0, done},    32'h0);
        chk("reset_illegal", {31'b0, illegal}, 32'h0);
        chk("reset_result",  result,           32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'b0, busy}, 32'h0);
        chk("idle_done", {31'b0, done}, 32'h0);

        // Directed cases with hand-computed results, chained back to back.
        issue(F7_MEXT, F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 1, t0);
        issue(F7_MEXT, F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 1, t0);
        issue(F7_MEXT, F3_MULH,   32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 1, t0);
        issue(F7_MEXT, F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 1, 32'hFFFF_FFFF, 1, t0);
        issue(F7_MEXT, F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFD, 1, t0);
        issue(F7_MEXT, F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 1, 32'hFFFF_FFFF, 1, t0);
        issue(F7_MEXT, F3_DIVU,   32'h0000_0005, 32'h0000_0000, 1, 32'hFFFF_FFFF, 1, t0);
        issue(F7_MEXT, F3_REMU,   32'h0000_0005, 32'h0000_0000, 1, 32'h0000_0005, 1, t0);
        issue(F7_MEXT, F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, t0);
        issue(F7_MEXT, F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1, t0);
        issue(7'b0100000, F3_MUL, 32'h0000_0003, 32'h0000_0004, 1, 32'h0000_0000, 1, t0);

        // A new request raised while busy must not disturb the operation in flight.
        issue(F7_MEXT, F3_DIVU, 32'd1000, 32'd7, 1, 32'd142, 1, t0);
        func3 = F3_MUL;
        rs1   = 32'h0000_DEAD;
        rs2   = 32'h0000_0003;
        repeat (4) @(negedge clk);
        drain();

        // Flush in the middle of a divide.
        issue(F7_MEXT, F3_DIV, 32'd1234567, 32'd89, 0, 32'h0, 0, t0);
        start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy",   {31'b0, busy}, 32'h0);
        chk("flush_done",   {31'b0, done}, 32'h0);
        chk("flush_result", result, last_res);
        idle(40);

        // Flush beats start in the same cycle.
        func7 = F7_MEXT;
        func3 = F3_MUL;
        rs1   = 32'd11;
        rs2   = 32'd13;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {31'b0, busy}, 32'h0);
        chk("flush_start_done", {31'b0, done}, 32'h0);
        idle(3);

        // Asynchronous reset during CALC.
        issue(F7_MEXT, F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'h0, 0, t0);
        start = 1'b0;
        while (cyc < t0 + 6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",    {31'b0, busy},    32'h0);
        chk("midrst_done",    {31'b0, done},    32'h0);
        chk("midrst_illegal", {31'b0, illegal}, 32'h0);
        chk("midrst_result",  result,           32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_res = '0;
        idle(2);

        // Randomized operations, with occasional idle gaps.
        for (int i = 0; i < 150; i++) begin
            f7 = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(0, 127)) : F7_MEXT;
            f3 = 3'($urandom_range(0, 7));
            a  = rnd_operand();
            b  = rnd_operand();
            issue(f7, f3, a, b, 0, 32'h0, 1, t0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        chk("scoreboard_empty", sb_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
